// File: rtl/tx_serializer_pkg.sv
// Shared flit-width defines and transmitter state encodings.
// Frame format: start bit '1', flit LSB first, then GUARD_CYCLES zeros.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef FLIT_BITS
`define FLIT_BITS (`PAYLOAD_SIZE + `ADDR_BITS)
`endif

package tx_serializer_pkg;

  localparam int FLIT_W = `FLIT_BITS;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SEND  = 2'd1,
    TX_GUARD = 2'd2
  } tx_state_e;

  // Start bit sits in bit 0 so the whole frame shifts out LSB first.
  function automatic logic [FLIT_W:0] frame_word(input logic [FLIT_W-1:0] flit);
    return {flit, 1'b1};
  endfunction

endpackage

// File: rtl/tx_serializer.sv
// Link-level serial transmitter with a one-entry holding register.
// Optional frame counter output frames_sent is built only when TX_STATS_EN is defined.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef FLIT_BITS
`define FLIT_BITS (`PAYLOAD_SIZE + `ADDR_BITS)
`endif

module tx_serializer
  import tx_serializer_pkg::*;
#(
  parameter int    routerid     = -1,
  parameter string port         = "unknown",
  parameter int    GUARD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready,
  input  logic [FLIT_W-1:0] parallel_in,
  input  logic              channel_busy,
  output logic              serial_out,
  output logic              busy
`ifdef TX_STATS_EN
  ,
  output logic [15:0]       frames_sent
`endif
);

  // Handshake: a flit transfers on a rising clk edge where valid_in & ready;
  // ready is the registered "holding register empty" flag, no combinational path.

  localparam logic [7:0] CNT_LOAD  = 8'(FLIT_W);
  // GUARD_CYCLES must lie in 1..15 so the 4-bit guard counter covers it.
  localparam logic [3:0] GCNT_LOAD = 4'(GUARD_CYCLES - 1);

  tx_state_e         state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [FLIT_W-1:0] hold_data_q, hold_data_d;
  logic [FLIT_W:0]   shreg_q, shreg_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        gcnt_q, gcnt_d;
`ifdef TX_STATS_EN
  logic [15:0]       frames_q, frames_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= TX_IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gcnt_q      <= '0;
`ifdef TX_STATS_EN
      frames_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
`ifdef TX_STATS_EN
      frames_q    <= frames_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
`ifdef TX_STATS_EN
    frames_d    = frames_q;
`endif

    if (valid_in && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = parallel_in;
    end

    unique case (state_q)
      TX_IDLE: begin
        // channel_busy only matters here; once launched the frame runs to completion.
        if (hold_full_q && !channel_busy) begin
          shreg_d     = frame_word(hold_data_q);
          cnt_d       = CNT_LOAD;
          hold_full_d = 1'b0;
          state_d     = TX_SEND;
        end
      end
      TX_SEND: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
          gcnt_d  = GCNT_LOAD;
          state_d = TX_GUARD;
`ifdef TX_STATS_EN
          frames_d = frames_q + 16'd1;
`endif
        end
      end
      TX_GUARD: begin
        gcnt_d = gcnt_q - 4'd1;
        if (gcnt_q == 4'd0) begin
          state_d = TX_IDLE;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  assign ready      = !hold_full_q;
  assign serial_out = (state_q == TX_SEND) && shreg_q[0];
  assign busy       = (state_q != TX_IDLE) || hold_full_q;
`ifdef TX_STATS_EN
  assign frames_sent = frames_q;
`endif

endmodule
